dpram_portb_arbiter: RTL and testbench

- Owns FPGA-side port B of the 1024x16 DSP-shared dual-port RAM.
- Arbitrates single-word accesses between the FPGA write requester (status/telemetry to the DSP) and the FPGA read requester (DSP parameters to the FPGA).
- Blocks port-B accesses that would collide with an in-flight DSP port-A write.
- Sequences the active-low XINT1 "frame ready" interrupt so it fires only after all pending FPGA writes have landed.

---
 rtl/dpram_portb_arbiter_if.sv | 37 +++
 rtl/dpram_portb_arbiter.sv | 141 ++++++++++++++
 tb/tb_dpram_portb_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_portb_arbiter_if.sv
// Signal bundle for the DSP-shared RAM port-B arbiter: requester channels, RAM port B,
// DSP port-A snoop, frame interrupt and statistics.
interface dpram_portb_arbiter_if;
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        ram_web;
    logic [9:0]  ram_addrb;
    logic [15:0] ram_dinb;
    logic [15:0] ram_doutb;
    logic        dsp_we;
    logic [9:0]  dsp_addr;
    logic        frame_done;
    logic        XINT1;
    logic [15:0] stat_defer_cnt;
    logic [15:0] stat_force_cnt;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb, dsp_we, dsp_addr,
               frame_done,
        output wr_ack, rd_ack, rd_data, rd_valid, ram_web, ram_addrb, ram_dinb, XINT1,
               stat_defer_cnt, stat_force_cnt
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, ram_doutb, dsp_we, dsp_addr,
               frame_done,
        input  wr_ack, rd_ack, rd_data, rd_valid, ram_web, ram_addrb, ram_dinb, XINT1,
               stat_defer_cnt, stat_force_cnt
    );
endinterface

// File: rtl/dpram_portb_arbiter.sv
// Port-B arbiter for the 1024x16 DSP-shared RAM: write/read arbitration with anti-starvation,
// DSP write collision deferral and gated XINT1. Define DPRAM_ARB_STAT_EN for the stat counters.
module dpram_portb_arbiter #(
    parameter int unsigned MAX_WR_STREAK = 4,
    parameter int unsigned INT_WIDTH     = 20
) (
    input  logic                  clk_100M,
    input  logic                  reset_n,
    dpram_portb_arbiter_if.slave  bus
);
    localparam int unsigned StreakW = $clog2(MAX_WR_STREAK + 1);
    localparam int unsigned IntCntW = (INT_WIDTH > 1) ? $clog2(INT_WIDTH) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_WR_STREAK);
    localparam logic [IntCntW-1:0] IntLoad   = IntCntW'(INT_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StWr, StRd, StRdWait} state_e;

    state_e              state_q;
    logic                wr_ack_q, rd_ack_q, rd_valid_q, ram_web_q;
    logic [9:0]          ram_addrb_q;
    logic [15:0]         ram_dinb_q, rd_data_q;
    logic [StreakW-1:0]  streak_q;
    logic                xint1_q, int_pend_q;
    logic [IntCntW-1:0]  int_cnt_q;

    logic wr_hit, rd_hit, wr_ok, rd_ok, force_rd, grant_wr, grant_rd, int_start;

    always_comb begin
        wr_hit    = bus.dsp_we && (bus.dsp_addr == bus.wr_addr);
        rd_hit    = bus.dsp_we && (bus.dsp_addr == bus.rd_addr);
        wr_ok     = bus.wr_req && !wr_hit;
        rd_ok     = bus.rd_req && !rd_hit;
        force_rd  = wr_ok && rd_ok && (streak_q == StreakMax);
        grant_wr  = (state_q == StIdle) && wr_ok && !force_rd;
        grant_rd  = (state_q == StIdle) && rd_ok && (!wr_ok || force_rd);
        // Fire only once all writes have landed and the previous pulse has fully ended.
        int_start = int_pend_q && !bus.wr_req && (state_q != StWr) && xint1_q;
    end

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            wr_ack_q    <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_web_q   <= 1'b0;
            ram_addrb_q <= '0;
            ram_dinb_q  <= '0;
            rd_data_q   <= '0;
            streak_q    <= '0;
            xint1_q     <= 1'b1;
            int_pend_q  <= 1'b0;
            int_cnt_q   <= '0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            ram_web_q  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (grant_wr) begin
                        state_q     <= StWr;
                        ram_web_q   <= 1'b1;
                        ram_addrb_q <= bus.wr_addr;
                        ram_dinb_q  <= bus.wr_data;
                        wr_ack_q    <= 1'b1;
                    end else if (grant_rd) begin
                        state_q     <= StRd;
                        ram_addrb_q <= bus.rd_addr;
                        rd_ack_q    <= 1'b1;
                    end
                end
                StWr:     state_q <= StIdle;
                StRd:     state_q <= StRdWait;
                StRdWait: begin
                    rd_data_q  <= bus.ram_doutb;
                    rd_valid_q <= 1'b1;
                    state_q    <= StIdle;
                end
                default:  state_q <= StIdle;
            endcase

            if (!bus.rd_req || grant_rd) begin
                streak_q <= '0;
            end else if (grant_wr && (streak_q != StreakMax)) begin
                streak_q <= streak_q + 1'b1;
            end

            if (bus.frame_done) begin
                int_pend_q <= 1'b1;
            end else if (int_start) begin
                int_pend_q <= 1'b0;
            end

            if (int_start) begin
                xint1_q   <= 1'b0;
                int_cnt_q <= IntLoad;
            end else if (!xint1_q) begin
                if (int_cnt_q == '0) begin
                    xint1_q <= 1'b1;
                end else begin
                    int_cnt_q <= int_cnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.wr_ack    = wr_ack_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.ram_web   = ram_web_q;
    assign bus.ram_addrb = ram_addrb_q;
    assign bus.ram_dinb  = ram_dinb_q;
    assign bus.XINT1     = xint1_q;

`ifdef DPRAM_ARB_STAT_EN
    logic [15:0] defer_cnt_q, force_cnt_q;
    logic        defer_evt, force_evt;

    assign defer_evt = (state_q == StIdle) && ((bus.wr_req && wr_hit) || (bus.rd_req && rd_hit));
    assign force_evt = (state_q == StIdle) && force_rd;

    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            defer_cnt_q <= '0;
            force_cnt_q <= '0;
        end else begin
            if (defer_evt && (defer_cnt_q != 16'hFFFF)) defer_cnt_q <= defer_cnt_q + 1'b1;
            if (force_evt && (force_cnt_q != 16'hFFFF)) force_cnt_q <= force_cnt_q + 1'b1;
        end
    end

    assign bus.stat_defer_cnt = defer_cnt_q;
    assign bus.stat_force_cnt = force_cnt_q;
`else
    assign bus.stat_defer_cnt = '0;
    assign bus.stat_force_cnt = '0;
`endif
endmodule

// File: tb/tb_dpram_portb_arbiter.sv
// Bench for dpram_portb_arbiter: directed scenarios then random single transactions checked
// against a shadow memory. Stat expectations follow DPRAM_ARB_STAT_EN.
module tb_dpram_portb_arbiter;
    localparam int unsigned MaxWrStreak = 4;
    localparam int unsigned IntWidth    = 20;
`ifdef DPRAM_ARB_STAT_EN
    localparam int ExpForce = 1;
    localparam int ExpDefer = 4;
`else
    localparam int ExpForce = 0;
    localparam int ExpDefer = 0;
`endif

    logic clk_100M = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clk_100M = ~clk_100M;

    dpram_portb_arbiter_if bus ();

    dpram_portb_arbiter #(
        .MAX_WR_STREAK (MaxWrStreak),
        .INT_WIDTH     (IntWidth)
    ) dut (
        .clk_100M (clk_100M),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    // Port-B RAM with a registered output.
    logic [15:0] mem [1024];
    always @(posedge clk_100M) begin
        if (bus.ram_web) mem[bus.ram_addrb] <= bus.ram_dinb;
        bus.ram_doutb <= mem[bus.ram_addrb];
    end

    // Reference: what every address must hold after the writes the bench has had acked.
    logic [15:0] shadow [1024];
    bit          written [1024];
    logic [9:0]  waddrs [$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic remember(input logic [9:0] a, input logic [15:0] d);
        shadow[a] = d;
        if (!written[a]) begin
            written[a] = 1'b1;
            waddrs.push_back(a);
        end
    endtask

    // Called in an IDLE cycle; returns in the next IDLE cycle.
    task automatic do_write(input logic [9:0] a, input logic [15:0] d);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_req  = 1'b1;
        tick();
        check("wr_ack", 32'(bus.wr_ack), 1);
        check("wr_web", 32'(bus.ram_web), 1);
        check("wr_addrb", 32'(bus.ram_addrb), 32'(a));
        check("wr_dinb", 32'(bus.ram_dinb), 32'(d));
        bus.wr_req = 1'b0;
        remember(a, d);
        tick();
        check("wr_web_off", 32'(bus.ram_web), 0);
    endtask

    task automatic do_read(input logic [9:0] a);
        bus.rd_addr = a;
        bus.rd_req  = 1'b1;
        tick();
        check("rd_ack", 32'(bus.rd_ack), 1);
        check("rd_addrb", 32'(bus.ram_addrb), 32'(a));
        bus.rd_req = 1'b0;
        tick();
        check("rd_valid_early", 32'(bus.rd_valid), 0);
        tick();
        check("rd_valid", 32'(bus.rd_valid), 1);
        check("rd_data", 32'(bus.rd_data), 32'(shadow[a]));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_web"}, 32'(bus.ram_web), 0);
        check({tag, "_wr_ack"}, 32'(bus.wr_ack), 0);
        check({tag, "_rd_ack"}, 32'(bus.rd_ack), 0);
        check({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
        check({tag, "_addrb"}, 32'(bus.ram_addrb), 0);
        check({tag, "_dinb"}, 32'(bus.ram_dinb), 0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 0);
        check({tag, "_xint1"}, 32'(bus.XINT1), 1);
        check({tag, "_defer"}, 32'(bus.stat_defer_cnt), 0);
        check({tag, "_force"}, 32'(bus.stat_force_cnt), 0);
    endtask

    initial begin
        int n_wr;
        int n_rd;
        int n_low;
        bit got_rd;
        logic [9:0]  a;
        logic [15:0] d;

        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.dsp_we = 1'b0; bus.dsp_addr = '0; bus.frame_done = 1'b0;

        tick();
        tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Single write and single read.
        do_write(10'h105, 16'hA5A5);
        do_write(10'h012, 16'h1234);
        do_write(10'h020, 16'h2020);
        do_read(10'h012);

        // Starvation: continuous writes versus a pending read.
        bus.wr_addr = 10'h200; bus.wr_data = 16'h5555; bus.wr_req = 1'b1;
        bus.rd_addr = 10'h012; bus.rd_req = 1'b1;
        n_wr = 0;
        got_rd = 1'b0;
        for (int i = 0; i < 40 && !got_rd; i++) begin
            tick();
            if (bus.wr_ack) n_wr++;
            if (bus.rd_ack) got_rd = 1'b1;
        end
        check("starve_rd_grant", 32'(got_rd), 1);
        check("starve_wr_grants", n_wr, MaxWrStreak);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        remember(10'h200, 16'h5555);
        tick();
        tick();
        check("starve_rd_valid", 32'(bus.rd_valid), 1);
        check("starve_rd_data", 32'(bus.rd_data), 32'(16'h1234));
        check("starve_force_cnt", 32'(bus.stat_force_cnt), ExpForce);

        // Collision: DSP writing the read address for 5 cycles.
        bus.dsp_we = 1'b1; bus.dsp_addr = 10'h020;
        bus.rd_addr = 10'h020; bus.rd_req = 1'b1;
        bus.wr_addr = 10'h110; bus.wr_data = 16'h0BEE; bus.wr_req = 1'b1;
        n_wr = 0;
        n_rd = 0;
        repeat (5) begin
            tick();
            if (bus.wr_ack) begin
                n_wr++;
                bus.wr_req = 1'b0;
            end
            if (bus.rd_ack) n_rd++;
        end
        remember(10'h110, 16'h0BEE);
        check("coll_wr_grants", n_wr, 1);
        check("coll_rd_blocked", n_rd, 0);
        bus.dsp_we = 1'b0;
        tick();
        check("coll_rd_ack", 32'(bus.rd_ack), 1);
        bus.rd_req = 1'b0;
        tick();
        tick();
        check("coll_rd_valid", 32'(bus.rd_valid), 1);
        check("coll_rd_data", 32'(bus.rd_data), 32'(16'h2020));
        check("coll_defer_cnt", 32'(bus.stat_defer_cnt), ExpDefer);

        // Interrupt gating behind three writes, then a re-armed second pulse.
        bus.frame_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 10'h300 + 10'(i);
            d = 16'hC000 + 16'(i);
            bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
            tick();
            bus.frame_done = 1'b0;
            check("int_wr_ack", 32'(bus.wr_ack), 1);
            check("int_gated", 32'(bus.XINT1), 1);
            remember(a, d);
            if (i == 2) bus.wr_req = 1'b0;
            else tick();
        end
        tick();
        check("int_hold", 32'(bus.XINT1), 1);
        tick();
        check("int_fall", 32'(bus.XINT1), 0);
        n_low = 0;
        while (bus.XINT1 === 1'b0 && n_low < 60) begin
            bus.frame_done = (n_low == 5);
            n_low++;
            tick();
        end
        bus.frame_done = 1'b0;
        check("int_width", n_low, IntWidth);
        check("int_gap", 32'(bus.XINT1), 1);
        tick();
        check("int_second", 32'(bus.XINT1), 0);
        n_low = 0;
        while (bus.XINT1 === 1'b0 && n_low < 60) begin
            n_low++;
            tick();
        end
        check("int_width2", n_low, IntWidth);

        // Reset during RD_WAIT.
        bus.rd_addr = 10'h105; bus.rd_req = 1'b1;
        tick();
        check("rst_rd_ack", 32'(bus.rd_ack), 1);
        bus.rd_req = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_values("rst_async");
        tick();
        check("rst_no_valid", 32'(bus.rd_valid), 0);
        tick();
        check("rst_no_valid2", 32'(bus.rd_valid), 0);
        reset_n = 1'b1;
        tick();
        do_read(10'h105);

        // Random single transactions with a non-colliding DSP write in flight.
        for (int i = 0; i < 40; i++) begin
            bus.dsp_we = 1'($urandom_range(0, 1));
            if (waddrs.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = 10'($urandom_range(0, 1023));
                d = 16'($urandom);
                bus.dsp_addr = a ^ 10'h001;
                do_write(a, d);
            end else begin
                a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                bus.dsp_addr = a ^ 10'h001;
                do_read(a);
            end
        end
        bus.dsp_we = 1'b0;
        check("final_defer_cnt", 32'(bus.stat_defer_cnt), 0);
        check("final_force_cnt", 32'(bus.stat_force_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
